eth_header_buffer: RTL
======================

ETH_HEADER_BUFFER -- requirements
Module: eth_header_buffer

Interface
REQ-001 Parameter DATA_WIDTH, default 8, width of RAM word, MM data and stream data.
REQ-002 Parameter ADDR_WIDTH, default 8, RAM address width; DEPTH = 2**ADDR_WIDTH words.
REQ-003 Parameter INIT_FILE, default "eth_header_buffer.hex", RAM power-up contents.
REQ-004 clk  in  1  sole clock; all logic on rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 address  in  ADDR_WIDTH  MM slave word address.
REQ-007 chipselect  in  1  MM slave select.
REQ-008 write  in  1  MM write strobe; write occurs when chipselect & write.
REQ-009 writedata  in  DATA_WIDTH  MM write data.
REQ-010 readdata  out  DATA_WIDTH  MM read data, fixed read latency 1.
REQ-011 start  in  1  one-cycle pulse requesting header emission.
REQ-012 hdr_len  in  ADDR_WIDTH+1  number of words to emit, sampled on accepted start.
REQ-013 busy  out  1  high from accepted start until last beat accepted.
REQ-014 done  out  1  one-cycle pulse when emission completes.
REQ-015 src_data  out  DATA_WIDTH  Avalon-ST source data.
REQ-016 src_valid / src_sop / src_eop  out  1 each  Avalon-ST qualifiers.
REQ-017 src_ready  in  1  Avalon-ST sink ready, ready latency 0.

Function
REQ-018 The RAM SHALL be a simple dual-port: MM port read/write, stream port read-only, both synchronous with 1-cycle latency.
REQ-019 readdata SHALL present mem[address] registered one cycle after any cycle with chipselect, regardless of write.
REQ-020 FSM states SHALL be IDLE, STREAM, FLUSH; reset state IDLE.
REQ-021 IDLE: start with hdr_len != 0 SHALL latch len = min(hdr_len, DEPTH), clear read pointer, assert busy, go STREAM.
REQ-022 start with hdr_len == 0 SHALL pulse done the next cycle with no beats and busy never asserted.
REQ-023 start while busy SHALL be ignored.
REQ-024 STREAM: a RAM read SHALL be issued whenever reads issued < len and the 2-entry output FIFO has room counting in-flight read; pointer increments per issue.
REQ-025 When all reads issued, FSM SHALL go FLUSH; FLUSH SHALL return to IDLE on the cycle the eop beat is accepted.
REQ-026 Beat transfer SHALL occur when src_valid & src_ready; src_data SHALL hold stable while src_valid & ~src_ready.
REQ-027 src_sop SHALL mark beat 0, src_eop beat len-1; len == 1 asserts both on the single beat.
REQ-028 Stream throughput SHALL be one beat per cycle while src_ready stays high; first beat valid 2 cycles after start.
REQ-029 done SHALL pulse the cycle after eop acceptance, busy deasserting in that same cycle.
REQ-030 MM writes during emission SHALL be allowed; a same-address same-cycle MM write and stream read SHALL return old data to the stream.
REQ-031 hdr_len > DEPTH SHALL clamp to DEPTH; pointer never wraps within one emission.

Reset
REQ-032 Reset SHALL force IDLE, busy=0, done=0, src_valid=0, src_sop=0, src_eop=0, readdata=0, src_data=0, FIFO empty, pointer 0.
REQ-033 Reset mid-emission SHALL abort immediately with no eop; RAM contents SHALL be retained.

Configuration
REQ-034 With HDR_BUF_CHECKSUM_EN defined, output csum[15:0] SHALL hold the 16-bit ones'-complement sum of emitted bytes paired big-endian (odd last byte padded low with 0), cleared at start, final value valid when done pulses, reset to 0; macro requires DATA_WIDTH == 8.
REQ-035 Without HDR_BUF_CHECKSUM_EN, the csum port and its logic SHALL be absent; all other behaviour identical.

Verification
REQ-036 MM write 0xA5 at addr 3, read addr 3 -> readdata 0xA5 one cycle later.
REQ-037 mem[0..13]=0x00..0x0D, start hdr_len=14, src_ready=1 -> 14 consecutive beats 0x00..0x0D, sop on first, eop on 14th, done one cycle after.
REQ-038 Same load, src_ready toggling 1/0 each cycle -> identical sequence, no loss/duplicate, data stable while stalled.
REQ-039 start hdr_len=0 -> done pulse next cycle, src_valid never high; start hdr_len=300 (ADDR_WIDTH=8) -> exactly 256 beats.
REQ-040 reset asserted after beat 5 of 14 -> all outputs 0 asynchronously; subsequent start emits from beat 0 with original RAM data.
REQ-041 HDR_BUF_CHECKSUM_EN, bytes 0x45,0x00,0x00,0x1C,0x01 -> csum 0x461C at done.

Source files
------------

// File: rtl/eth_header_buffer.sv
// eth_header_buffer: dual-port header RAM with an Avalon-MM slave for
// host access and an Avalon-ST source that replays the first hdr_len
// words as one packet per start pulse.
// Optional build macro HDR_BUF_CHECKSUM_EN adds a csum output carrying the
// 16-bit ones'-complement sum of the emitted bytes (needs DATA_WIDTH == 8).
module eth_header_buffer #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter     INIT_FILE  = "eth_header_buffer.hex"
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic                  chipselect,
    input  logic                  write,
    input  logic [DATA_WIDTH-1:0] writedata,
    output logic [DATA_WIDTH-1:0] readdata,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   hdr_len,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] src_data,
    output logic                  src_valid,
    output logic                  src_sop,
    output logic                  src_eop,
    input  logic                  src_ready
`ifdef HDR_BUF_CHECKSUM_EN
    ,
    output logic [15:0]           csum
`endif
);

    localparam int                DEPTH   = 2 ** ADDR_WIDTH;
    localparam int                CW      = ADDR_WIDTH + 1;
    localparam logic [CW-1:0]     DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, STREAM, FLUSH} state_t;

    // RAM preload from INIT_FILE is applied by the device memory-init flow;
    // no simulation logic consumes it here.
    if (INIT_FILE == "") begin : g_no_preload
    end

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    state_t                       state_q, state_d;
    logic [CW-1:0]                len_q, len_d;
    logic [CW-1:0]                ptr_q, ptr_d;
    logic                         done_q, done_d;
    logic [DATA_WIDTH-1:0]        readdata_q, readdata_d;
    logic [DATA_WIDTH-1:0]        rd_data_q, rd_data_d;
    logic                         pend_q, pend_d;
    logic                         pend_sop_q, pend_sop_d;
    logic                         pend_eop_q, pend_eop_d;
    logic [1:0][DATA_WIDTH-1:0]   fifo_data_q, fifo_data_d;
    logic [1:0]                   fifo_sop_q, fifo_sop_d;
    logic [1:0]                   fifo_eop_q, fifo_eop_d;
    logic                         head_q, head_d;
    logic                         tail_q, tail_d;
    logic [1:0]                   count_q, count_d;

    logic                         rd_issue;
    logic [ADDR_WIDTH-1:0]        rd_addr;
    logic                         issue_sop, issue_eop;
    logic                         pop;
    logic                         room;
    logic [2:0]                   occ;
    logic [CW-1:0]                len_clamp;

    // Output FIFO occupancy including the read still in flight decides
    // whether another RAM read may be launched this cycle.
    always_comb begin
        pop       = (count_q != 2'd0) && src_ready;
        occ       = {1'b0, count_q} + {2'b00, pend_q} - {2'b00, pop};
        room      = (occ < 3'd2);
        len_clamp = (hdr_len > DEPTH_C) ? DEPTH_C : hdr_len;
    end

    // Control FSM: accepts start in IDLE, issues reads in STREAM, waits
    // for the eop beat to drain in FLUSH.
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        ptr_d     = ptr_q;
        done_d    = 1'b0;
        rd_issue  = 1'b0;
        rd_addr   = ptr_q[ADDR_WIDTH-1:0];
        issue_sop = 1'b0;
        issue_eop = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (hdr_len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        // Word 0 is fetched in the start cycle so the first
                        // beat is valid two cycles after start.
                        len_d     = len_clamp;
                        rd_issue  = 1'b1;
                        rd_addr   = '0;
                        issue_sop = 1'b1;
                        issue_eop = (len_clamp == CW'(1));
                        ptr_d     = CW'(1);
                        state_d   = STREAM;
                    end
                end
            end
            STREAM: begin
                if ((ptr_q < len_q) && room) begin
                    rd_issue  = 1'b1;
                    issue_eop = (ptr_q == len_q - CW'(1));
                    ptr_d     = ptr_q + CW'(1);
                end
                if (ptr_d == len_q) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                if (pop && src_eop) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    ptr_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // RAM read ports: MM read every chipselect cycle, stream read on issue.
    always_comb begin
        readdata_d = chipselect ? mem[address] : readdata_q;
        rd_data_d  = rd_issue ? mem[rd_addr] : rd_data_q;
        pend_d     = rd_issue;
        pend_sop_d = issue_sop;
        pend_eop_d = issue_eop;
    end

    // Two-entry output FIFO fed by the RAM read register.
    always_comb begin
        fifo_data_d = fifo_data_q;
        fifo_sop_d  = fifo_sop_q;
        fifo_eop_d  = fifo_eop_q;
        head_d      = head_q;
        tail_d      = tail_q;
        if (pend_q) begin
            fifo_data_d[tail_q] = rd_data_q;
            fifo_sop_d[tail_q]  = pend_sop_q;
            fifo_eop_d[tail_q]  = pend_eop_q;
            tail_d              = ~tail_q;
        end
        if (pop) begin
            head_d = ~head_q;
        end
        count_d = count_q + {1'b0, pend_q} - {1'b0, pop};
    end

    // MM write port; a write and a stream read to one address in the same
    // cycle returns the old word to the stream.
    always_ff @(posedge clk) begin
        if (chipselect && write) begin
            mem[address] <= writedata;
        end
    end

    // Stream RAM read register; its content is qualified by pend_q.
    always_ff @(posedge clk) begin
        rd_data_q <= rd_data_d;
    end

    // Control and output state with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            len_q       <= '0;
            ptr_q       <= '0;
            done_q      <= 1'b0;
            readdata_q  <= '0;
            pend_q      <= 1'b0;
            pend_sop_q  <= 1'b0;
            pend_eop_q  <= 1'b0;
            fifo_data_q <= '0;
            fifo_sop_q  <= '0;
            fifo_eop_q  <= '0;
            head_q      <= 1'b0;
            tail_q      <= 1'b0;
            count_q     <= 2'd0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            ptr_q       <= ptr_d;
            done_q      <= done_d;
            readdata_q  <= readdata_d;
            pend_q      <= pend_d;
            pend_sop_q  <= pend_sop_d;
            pend_eop_q  <= pend_eop_d;
            fifo_data_q <= fifo_data_d;
            fifo_sop_q  <= fifo_sop_d;
            fifo_eop_q  <= fifo_eop_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
        end
    end

    assign readdata  = readdata_q;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign src_valid = (count_q != 2'd0);
    assign src_data  = fifo_data_q[head_q];
    assign src_sop   = src_valid && fifo_sop_q[head_q];
    assign src_eop   = src_valid && fifo_eop_q[head_q];

`ifdef HDR_BUF_CHECKSUM_EN
    logic [15:0] csum_q, csum_d;
    logic        odd_q, odd_d;
    logic [15:0] csum_word;
    logic [16:0] csum_sum;

    // Running ones'-complement sum; even bytes land in the high half of a
    // 16-bit word, odd bytes in the low half, end-around carry per beat.
    always_comb begin
        csum_d    = csum_q;
        odd_d     = odd_q;
        csum_word = odd_q ? {8'h00, src_data[7:0]} : {src_data[7:0], 8'h00};
        csum_sum  = {1'b0, csum_q} + {1'b0, csum_word};
        if ((state_q == IDLE) && start) begin
            csum_d = '0;
            odd_d  = 1'b0;
        end else if (pop) begin
            csum_d = csum_sum[15:0] + {15'd0, csum_sum[16]};
            odd_d  = ~odd_q;
        end
    end

    // Checksum state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            csum_q <= '0;
            odd_q  <= 1'b0;
        end else begin
            csum_q <= csum_d;
            odd_q  <= odd_d;
        end
    end

    assign csum = csum_q;
`endif

endmodule
